// File: rtl/if_id_queue.sv
// IF/ID decoupling stage: in-order instruction queue
// feeding a registered decode-side output.
module if_id_queue #(
  parameter int WORD_BITWIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INSN = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       hazard,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [WORD_BITWIDTH-1:0]   pc,
  input  logic [WORD_BITWIDTH-1:0]   instruction,
  output logic                       id_valid,
  output logic [WORD_BITWIDTH-1:0]   id_wt_pc,
  output logic [WORD_BITWIDTH-1:0]   id_instruction,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef logic [WORD_BITWIDTH-1:0] word_t;

  word_t         pc_mem  [DEPTH];
  word_t         ins_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic push;
  logic advance;
  logic empty;
  logic pop;
  logic write;

  assign empty    = (count == '0);
  assign if_ready = (count != FULL);
  assign push     = if_valid & if_ready & ~flush;
  assign advance  = ~hazard & ~flush;
  assign pop      = advance & ~empty;
  // an empty queue with a moving output bypasses storage
  assign write    = push & ~(advance & empty);

  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (!rst && write) begin
      pc_mem[wr_ptr]  <= pc;
      ins_mem[wr_ptr] <= instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(write) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_valid       <= 1'b0;
      id_wt_pc       <= '0;
      id_instruction <= NOP_INSN;
    end else if (advance) begin
      if (!empty) begin
        id_valid       <= 1'b1;
        id_wt_pc       <= pc_mem[rd_ptr];
        id_instruction <= ins_mem[rd_ptr];
      end else if (push) begin
        id_valid       <= 1'b1;
        id_wt_pc       <= pc;
        id_instruction <= instruction;
      end else begin
        id_valid       <= 1'b0;
        id_wt_pc       <= '0;
        id_instruction <= NOP_INSN;
      end
    end
  end

  a_count_bound: assert property (
    @(posedge clk) disable iff (rst) count <= FULL
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized bench for if_id_queue against a
// queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        hazard;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        id_valid;
  logic [31:0] id_wt_pc;
  logic [31:0] id_instruction;
  logic [2:0]  occupancy;

  if_id_queue #(
    .WORD_BITWIDTH(32),
    .DEPTH(DEPTH),
    .NOP_INSN(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .hazard(hazard),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .pc(pc),
    .instruction(instruction),
    .id_valid(id_valid),
    .id_wt_pc(id_wt_pc),
    .id_instruction(id_instruction),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] mq[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic        known = 1'b0;
  logic [31:0] fpc = '0;
  logic [31:0] salt;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] p);
    return p ^ salt;
  endfunction

  task automatic step(input logic r, input logic f,
                      input logic h, input logic v);
    logic acc;
    logic [63:0] e;
    rst = r;
    flush = f;
    hazard = h;
    if_valid = v;
    pc = fpc;
    instruction = ins_of(fpc);
    #1;
    if (known)
      check("if_ready", 64'(if_ready),
            64'(mq.size() != DEPTH));
    @(posedge clk);
    acc = 1'b0;
    if (r || f) begin
      mq.delete();
      m_valid = 1'b0;
      m_pc = '0;
      m_ins = NOP;
      known = 1'b1;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (!h) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_valid = 1'b1;
          m_pc = e[63:32];
          m_ins = e[31:0];
          if (acc) mq.push_back({pc, instruction});
        end else if (acc) begin
          m_valid = 1'b1;
          m_pc = pc;
          m_ins = instruction;
        end else begin
          m_valid = 1'b0;
          m_pc = '0;
          m_ins = NOP;
        end
      end else if (acc) begin
        mq.push_back({pc, instruction});
      end
    end
    if (acc || ((r || f) && v)) fpc = fpc + 32'd4;
    #1;
    check("id_valid", 64'(id_valid), 64'(m_valid));
    check("id_wt_pc", 64'(id_wt_pc), 64'(m_pc));
    check("id_instruction", 64'(id_instruction), 64'(m_ins));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
  endtask

  initial begin
    salt = $urandom;
    rst = 1'b1;
    flush = 1'b0;
    hazard = 1'b0;
    if_valid = 1'b0;
    pc = '0;
    instruction = '0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_ready", 64'(if_ready), 64'd1);

    // streaming
    fpc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      check("stream_pc", 64'(id_wt_pc), 64'(i * 4));
    end

    // stall fill
    fpc = 32'h100;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
    check("fill_occ", 64'(occupancy), 64'd4);
    check("fill_ready", 64'(if_ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("drain_pc", 64'(id_wt_pc), 64'(32'h100 + i * 4));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // bubble then a single push
    check("bubble_v", 64'(id_valid), 64'd0);
    check("bubble_ins", 64'(id_instruction), 64'(NOP));
    fpc = 32'h200;
    step(0, 0, 0, 1);
    check("single_pc", 64'(id_wt_pc), 64'h200);
    step(0, 0, 0, 0);

    // push/pop at occupancy 2 across wraps
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    for (int i = 0; i < 3 * DEPTH; i++) step(0, 0, 0, 1);
    check("pp_occ", 64'(occupancy), 64'd2);

    // flush mid-stall
    step(0, 0, 1, 1);
    check("pre_flush_occ", 64'(occupancy), 64'd3);
    step(0, 1, 1, 1);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_ins", 64'(id_instruction), 64'(NOP));
    check("flush_pc", 64'(id_wt_pc), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // reset mid-operation
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    check("pre_rst_occ", 64'(occupancy), 64'd4);
    step(1, 0, 1, 1);
    check("rst_mid_v", 64'(id_valid), 64'd0);
    check("rst_mid_rdy", 64'(if_ready), 64'd1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
